// File: rtl/product_accumulator_if.sv
// Product-in / result-out handshake bundle for the accumulation stage.
interface product_accumulator_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;

  // Upstream multiplier feed plus downstream result consumer
  modport master (
    output in_valid, product, out_ready,
    input  in_ready, out_valid, acc_out, overflow
  );

  modport slave (
    input  in_valid, product, out_ready,
    output in_ready, out_valid, acc_out, overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Saturating sum of num_terms 8-bit products; result valid one cycle after the last transfer.
// Backpressure: in_ready high only while accumulating; result held in DONE until out_ready.
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  output logic             busy,
  product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] remaining_q;
  logic [ACC_W-1:0] acc_q;
  logic             overflow_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_d;
  logic             carry_d;

  // Carry-out of the widened add selects the saturated value
  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W+1)'(bus.product);
    carry_d  = sum_wide[ACC_W];
    acc_d    = carry_d ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q <= num_terms;
            acc_q       <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b1;
            if (num_terms == '0) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= S_ACCUM;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (bus.in_valid && in_ready_q) begin
            acc_q       <= acc_d;
            overflow_q  <= overflow_q | carry_d;
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_q;
  assign bus.overflow  = overflow_q;
  assign busy          = busy_q;

endmodule
